controle_lampada: RTL and testbench

Lamp control core of the smart lighting system. Combines the push button, the infrared presence sensor and the one-cycle auto-shutdown pulse `C` from the shutdown timer to drive the lamp output. It provides two modes:
- automatic (default): the lamp follows presence and the shutdown pulse.
- manual: the lamp is toggled by short button presses.

A long button press switches between the modes. This block is the consumer of the shutdown timer's `C` output.

---
 rtl/luz_pkg.sv | 15 +
 rtl/classificador_botao.sv | 76 +++++++
 rtl/controle_lampada.sv | 58 +++++
 tb/tb_controle_lampada.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/luz_pkg.sv
// Shared types and default timing constants for the smart lighting blocks.
package luz_pkg;

  // Button classifier states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } botao_state_t;

  // Default press thresholds, in clk cycles of button held high.
  localparam int DEBOUNCE_T_DEF        = 100;
  localparam int SWITCH_MODE_MIN_T_DEF = 5000;

endpackage

// File: rtl/classificador_botao.sv
// Button press classifier: counts consecutive high samples of the button and
// emits a one-cycle 'curto' (short press, on release) or 'longo' (long press,
// while still held). Both pulses are combinational so the consumer's
// registers react on the same edge that samples the deciding button level.
module classificador_botao
  import luz_pkg::*;
#(
  parameter int DEBOUNCE_T        = DEBOUNCE_T_DEF,
  parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  output logic curto,
  output logic longo
);

  localparam int TW = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam logic [TW-1:0] TP_MAX  = TW'(SWITCH_MODE_MIN_T);
  localparam logic [TW-1:0] TP_LONG = TW'(SWITCH_MODE_MIN_T - 1);
  localparam logic [TW-1:0] TP_DEB  = TW'(DEBOUNCE_T);
  localparam logic [TW-1:0] TP_ONE  = TW'(1);

  botao_state_t    state, state_nxt;
  logic [TW-1:0]   tp;

  // Consecutive-high counter: clears on any low sample, saturates at the
  // long-press threshold so a button held forever cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tp <= '0;
    else if (!push_button)
      tp <= '0;
    else if (tp != TP_MAX)
      tp <= tp + TP_ONE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and press pulses. tp holds the number of highs seen before
  // the current sample, so tp == SWITCH_MODE_MIN_T-1 with the button still
  // high means this sample is the long-press threshold.
  always_comb begin
    state_nxt = state;
    curto     = 1'b0;
    longo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (push_button)
          state_nxt = PRESS;
      end
      PRESS: begin
        if (!push_button) begin
          curto     = (tp >= TP_DEB);
          state_nxt = IDLE;
        end else if (tp == TP_LONG) begin
          longo     = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        // Release after a long press is deliberately silent.
        if (!push_button)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/controle_lampada.sv
// Lamp control core: automatic mode follows presence and the shutdown pulse,
// manual mode toggles the lamp on short presses; a long press swaps modes.
module controle_lampada
  import luz_pkg::*;
#(
  parameter int DEBOUNCE_T        = DEBOUNCE_T_DEF,
  parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic C,
  output logic L,
  output logic manual
);

  logic curto, longo;

  classificador_botao #(
    .DEBOUNCE_T       (DEBOUNCE_T),
    .SWITCH_MODE_MIN_T(SWITCH_MODE_MIN_T)
  ) u_botao (
    .clk        (clk),
    .rst        (rst),
    .push_button(push_button),
    .curto      (curto),
    .longo      (longo)
  );

  // Mode register: flips on each long press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      manual <= 1'b0;
    else if (longo)
      manual <= ~manual;
  end

  // Lamp register. The lamp holds through the mode-toggle cycle; the new
  // mode's rules start on the following cycle. In automatic mode presence
  // beats the shutdown pulse when both arrive together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      L <= 1'b0;
    else if (longo)
      L <= L;
    else if (manual) begin
      if (curto)
        L <= ~L;
    end else begin
      if (infravermelho)
        L <= 1'b1;
      else if (C)
        L <= 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_lampada.sv
// Directed bench for controle_lampada with DEBOUNCE_T=4, SWITCH_MODE_MIN_T=10.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the
// following rising edge.
module tb_controle_lampada;

  localparam int DEB = 4;
  localparam int SWM = 10;

  logic clk = 1'b0;
  logic rst;
  logic push_button;
  logic infravermelho;
  logic C;
  logic L;
  logic manual;

  int n_cmp = 0;
  int n_bad = 0;

  controle_lampada #(
    .DEBOUNCE_T       (DEB),
    .SWITCH_MODE_MIN_T(SWM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .C            (C),
    .L            (L),
    .manual       (manual)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scenario 1: reset values, then 20 idle cycles.
  task automatic test_reset();
    rst = 1'b1; push_button = 1'b0; infravermelho = 1'b0; C = 1'b0;
    #2;
    n_cmp++;
    if (L !== 1'b0 || manual !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: L=%b manual=%b, required L=0 manual=0", L, manual);
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (L !== 1'b0 || manual !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_cycle%0d: L=%b manual=%b, required L=0 manual=0", i, L, manual);
      end
    end
  endtask

  // Scenario 2: automatic mode presence / shutdown.
  task automatic test_auto();
    infravermelho = 1'b1;
    step();
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL auto_presence_on: L=%b, required 1", L); end
    for (int i = 0; i < 4; i++) step();
    infravermelho = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL auto_presence_off_hold: L=%b, required 1", L); end
    C = 1'b1;
    step();
    C = 1'b0;
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL auto_shutdown: L=%b, required 0", L); end
    // Repeated shutdown pulse with lamp already off.
    C = 1'b1;
    step();
    C = 1'b0;
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL auto_repeat_C: L=%b, required 0", L); end
    // Presence and shutdown together: presence wins.
    infravermelho = 1'b1; C = 1'b1;
    step();
    infravermelho = 1'b0; C = 1'b0;
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL auto_C_and_presence: L=%b, required 1", L); end
    step();
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL auto_hold_after_both: L=%b, required 1", L); end
    // Short press in automatic mode is ignored.
    push_button = 1'b1;
    for (int i = 0; i < 5; i++) step();
    push_button = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b1 || manual !== 1'b0) begin
      n_bad++;
      $display("FAIL auto_short_press_ignored: L=%b manual=%b, required L=1 manual=0", L, manual);
    end
    // Turn lamp off for the next scenario.
    C = 1'b1;
    step();
    C = 1'b0;
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL auto_shutdown2: L=%b, required 0", L); end
  endtask

  // Scenario 3: long press into manual, glitch press, debounce-length press.
  task automatic test_long_press();
    push_button = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (manual !== (k >= SWM) || L !== 1'b0) begin
        n_bad++;
        $display("FAIL long_press_sample%0d: manual=%b L=%b, required manual=%b L=0",
                 k, manual, L, (k >= SWM));
      end
    end
    push_button = 1'b0;
    step();
    n_cmp++;
    if (manual !== 1'b1 || L !== 1'b0) begin
      n_bad++;
      $display("FAIL long_release: manual=%b L=%b, required manual=1 L=0", manual, L);
    end
    // N = DEB-1: glitch.
    push_button = 1'b1;
    for (int i = 0; i < DEB - 1; i++) step();
    push_button = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL glitch_press: L=%b, required 0", L); end
    // N = DEB: toggles on release edge, not before.
    push_button = 1'b1;
    for (int i = 0; i < DEB; i++) step();
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL debounce_press_before_release: L=%b, required 0", L); end
    push_button = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL debounce_press_toggle: L=%b, required 1", L); end
  endtask

  // Scenario 4: manual mode ignores sensors, short press at SWM-1, long back.
  task automatic test_manual();
    infravermelho = 1'b1; step(); infravermelho = 1'b0; step();
    C = 1'b1; step(); C = 1'b0; step();
    n_cmp++;
    if (L !== 1'b1 || manual !== 1'b1) begin
      n_bad++;
      $display("FAIL manual_ignore_sensors: L=%b manual=%b, required L=1 manual=1", L, manual);
    end
    infravermelho = 1'b0; C = 1'b1; step(); C = 1'b0;
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL manual_ignore_C: L=%b, required 1", L); end
    // N = SWM-1: short press.
    push_button = 1'b1;
    for (int i = 0; i < SWM - 1; i++) step();
    n_cmp++;
    if (L !== 1'b1 || manual !== 1'b1) begin
      n_bad++;
      $display("FAIL press9_held: L=%b manual=%b, required L=1 manual=1", L, manual);
    end
    push_button = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b0 || manual !== 1'b1) begin
      n_bad++;
      $display("FAIL press9_toggle: L=%b manual=%b, required L=0 manual=1", L, manual);
    end
    // Set lamp on again so the mode toggle visibly holds it.
    push_button = 1'b1;
    for (int i = 0; i < DEB; i++) step();
    push_button = 1'b0;
    step();
    n_cmp++;
    if (L !== 1'b1) begin n_bad++; $display("FAIL manual_relight: L=%b, required 1", L); end
    // N = SWM: mode toggle only.
    push_button = 1'b1;
    for (int i = 0; i < SWM - 1; i++) step();
    n_cmp++;
    if (manual !== 1'b1) begin n_bad++; $display("FAIL press10_before_threshold: manual=%b, required 1", manual); end
    step();
    n_cmp++;
    if (manual !== 1'b0 || L !== 1'b1) begin
      n_bad++;
      $display("FAIL press10_mode_toggle: manual=%b L=%b, required manual=0 L=1", manual, L);
    end
    push_button = 1'b0;
    step();
    n_cmp++;
    if (manual !== 1'b0 || L !== 1'b1) begin
      n_bad++;
      $display("FAIL press10_release: manual=%b L=%b, required manual=0 L=1", manual, L);
    end
    // Back in automatic mode: shutdown pulse applies again.
    C = 1'b1; step(); C = 1'b0;
    n_cmp++;
    if (L !== 1'b0) begin n_bad++; $display("FAIL auto_again_C: L=%b, required 0", L); end
  endtask

  // Scenario 5: asynchronous reset in the middle of a press.
  task automatic test_reset_mid_press();
    // Enter manual mode and light the lamp.
    push_button = 1'b1;
    for (int i = 0; i < SWM; i++) step();
    push_button = 1'b0; step();
    push_button = 1'b1;
    for (int i = 0; i < DEB; i++) step();
    push_button = 1'b0; step();
    n_cmp++;
    if (L !== 1'b1 || manual !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_setup: L=%b manual=%b, required L=1 manual=1", L, manual);
    end
    push_button = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (L !== 1'b0 || manual !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: L=%b manual=%b, required L=0 manual=0", L, manual);
    end
    step(); step();
    rst = 1'b0;
    // Held 4 more samples: a fresh press of length 4. A counter that kept
    // its pre-reset value would reach the long threshold and flip the mode.
    for (int i = 0; i < DEB; i++) step();
    push_button = 1'b0;
    step();
    n_cmp++;
    if (manual !== 1'b0 || L !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_press: manual=%b L=%b, required manual=0 L=0", manual, L);
    end
    // Counter must restart from zero: a full long press is needed for manual.
    push_button = 1'b1;
    for (int i = 0; i < SWM - 1; i++) step();
    n_cmp++;
    if (manual !== 1'b0) begin n_bad++; $display("FAIL post_reset_long_early: manual=%b, required 0", manual); end
    step();
    n_cmp++;
    if (manual !== 1'b1) begin n_bad++; $display("FAIL post_reset_long: manual=%b, required 1", manual); end
    push_button = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_auto();
    test_long_press();
    test_manual();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
